// File: rtl/sm_route_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sm_route_sequencer
//
// Route controller for the soil-monitoring bot. A small programmable action
// table holds one action per node. The block watches the node count from the
// node detector. At each new node it either commands the motor/turn block or
// the soil sampler, using request/done handshakes. Line following is enabled
// only while the bot is travelling between nodes.
//
// Ports
//   clk_50       in   clock, all logic on the rising edge
//   reset        in   synchronous active-high reset
//   start        in   one-cycle pulse, begins the route (IDLE or DONE only)
//   route_len    in   [4:0] number of valid table entries (0..16), sampled on start
//   route_we     in   table write strobe (ignored while busy)
//   route_waddr  in   [3:0] table write address
//   route_wdata  in   [2:0] action code to write
//   nodes        in   [5:0] node count from the node detector
//   turn_done    in   turn finished
//   sample_done  in   sampling finished
//   reset_count  out  one-cycle clear of the node detector count
//   follow_en    out  line following enable
//   turn_req     out  turn request, held until turn_done
//   turn_cmd     out  [1:0] 00 straight, 01 left, 10 right, 11 U-turn
//   sample_req   out  sampling request, held until sample_done
//   node_index   out  [3:0] current / next table entry
//   busy         out  high outside IDLE, DONE and FAULT
//   done         out  route complete
//   fault        out  fault latched, cleared only by reset
// -----------------------------------------------------------------------------
module sm_route_sequencer #(
   parameter int unsigned ROUTE_DEPTH    = 16,
   parameter int unsigned TURN_TIMEOUT   = 100_000_000,
   parameter int unsigned SAMPLE_TIMEOUT = 500_000_000
) (
   input  logic       clk_50,
   input  logic       reset,
   input  logic       start,
   input  logic [4:0] route_len,
   input  logic       route_we,
   input  logic [3:0] route_waddr,
   input  logic [2:0] route_wdata,
   input  logic [5:0] nodes,
   input  logic       turn_done,
   input  logic       sample_done,
   output logic       reset_count,
   output logic       follow_en,
   output logic       turn_req,
   output logic [1:0] turn_cmd,
   output logic       sample_req,
   output logic [3:0] node_index,
   output logic       busy,
   output logic       done,
   output logic       fault
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLEAR,
      S_FOLLOW,
      S_FETCH,
      S_TURN,
      S_SAMPLE,
      S_ADVANCE,
      S_DONE,
      S_FAULT
   } state_t;

   // The timer starts at 0 in the first wait cycle, so comparing against
   // TIMEOUT-1 gives a request that is held for exactly TIMEOUT cycles.
   localparam logic [31:0] TURN_LIMIT   = 32'(TURN_TIMEOUT - 1);
   localparam logic [31:0] SAMPLE_LIMIT = 32'(SAMPLE_TIMEOUT - 1);

   state_t      state_q,      state_d;
   logic [4:0]  route_len_q,  route_len_d;
   logic [3:0]  node_index_q, node_index_d;
   logic [1:0]  turn_cmd_q,   turn_cmd_d;
   logic [5:0]  prev_nodes_q, prev_nodes_d;
   logic [31:0] timer_q,      timer_d;
   logic [2:0]  act_tab_q [ROUTE_DEPTH];
   logic [2:0]  act_tab_d [ROUTE_DEPTH];

   logic        node_event;
   logic        node_jump;
   logic [2:0]  fetch_code;
   logic        busy_w;

   assign busy_w = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAULT);

   // A step of exactly +1 (wrapping 63->0) is a node. A drop to 0 from
   // anywhere else is the detector clearing itself and is not an error.
   assign node_event = (nodes == (prev_nodes_q + 6'd1));
   assign node_jump  = (nodes != prev_nodes_q) && !node_event && (nodes != 6'd0);

   assign fetch_code = act_tab_q[node_index_q];

   // Action table: writes are locked out while a route is running.
   always_comb begin
      act_tab_d = act_tab_q;
      if (route_we && !busy_w) begin
         act_tab_d[route_waddr] = route_wdata;
      end
   end

   // Table contents deliberately survive reset.
   always_ff @(posedge clk_50) begin
      act_tab_q <= act_tab_d;
   end

   always_comb begin
      state_d      = state_q;
      route_len_d  = route_len_q;
      node_index_d = node_index_q;
      turn_cmd_d   = turn_cmd_q;
      prev_nodes_d = (state_q == S_CLEAR) ? 6'd0 : nodes;
      timer_d      = ((state_q == S_TURN) || (state_q == S_SAMPLE)) ? (timer_q + 32'd1) : 32'd0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               route_len_d  = route_len;
               node_index_d = 4'd0;
               state_d      = (route_len == 5'd0) ? S_DONE : S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d = S_FOLLOW;
         end
         S_FOLLOW: begin
            if (node_event) begin
               state_d = S_FETCH;
            end else if (node_jump) begin
               state_d = S_FAULT;
            end
         end
         S_FETCH: begin
            case (fetch_code)
               3'b000, 3'b001, 3'b010, 3'b011: begin
                  turn_cmd_d = fetch_code[1:0];
                  state_d    = S_TURN;
               end
               3'b100:  state_d = S_SAMPLE;
               3'b101:  state_d = S_DONE;
               default: state_d = S_FAULT;
            endcase
         end
         S_TURN: begin
            if (turn_done) begin
               state_d = S_ADVANCE;
            end else if (timer_q >= TURN_LIMIT) begin
               state_d = S_FAULT;
            end
         end
         S_SAMPLE: begin
            if (sample_done) begin
               state_d = S_ADVANCE;
            end else if (timer_q >= SAMPLE_LIMIT) begin
               state_d = S_FAULT;
            end
         end
         S_ADVANCE: begin
            // Compare in 5 bits so a 16-entry route ends after index 15.
            node_index_d = node_index_q + 4'd1;
            if (({1'b0, node_index_q} + 5'd1) == route_len_q) begin
               state_d = S_DONE;
            end else begin
               state_d = S_FOLLOW;
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_50) begin
      if (reset) begin
         state_q      <= S_IDLE;
         route_len_q  <= 5'd0;
         node_index_q <= 4'd0;
         turn_cmd_q   <= 2'd0;
         prev_nodes_q <= 6'd0;
         timer_q      <= 32'd0;
      end else begin
         state_q      <= state_d;
         route_len_q  <= route_len_d;
         node_index_q <= node_index_d;
         turn_cmd_q   <= turn_cmd_d;
         prev_nodes_q <= prev_nodes_d;
         timer_q      <= timer_d;
      end
   end

   // Outputs decode directly from the registered state.
   assign reset_count = (state_q == S_CLEAR);
   assign follow_en   = (state_q == S_FOLLOW);
   assign turn_req    = (state_q == S_TURN);
   assign turn_cmd    = (state_q == S_TURN) ? turn_cmd_q : 2'd0;
   assign sample_req  = (state_q == S_SAMPLE);
   assign node_index  = node_index_q;
   assign busy        = busy_w;
   assign done        = (state_q == S_DONE);
   assign fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_sm_route_sequencer.sv
`timescale 1ns/1ps
module tb_sm_route_sequencer;

   localparam int TT = 40;
   localparam int ST = 80;

   logic       clk_50 = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [4:0] route_len = 5'd0;
   logic       route_we = 1'b0;
   logic [3:0] route_waddr = 4'd0;
   logic [2:0] route_wdata = 3'd0;
   logic [5:0] nodes = 6'd0;
   logic       turn_done = 1'b0;
   logic       sample_done = 1'b0;
   logic       reset_count, follow_en, turn_req, sample_req, busy, done, fault;
   logic [1:0] turn_cmd;
   logic [3:0] node_index;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #10 clk_50 = ~clk_50;

   sm_route_sequencer #(
      .ROUTE_DEPTH(16), .TURN_TIMEOUT(TT), .SAMPLE_TIMEOUT(ST)
   ) dut (
      .clk_50(clk_50), .reset(reset), .start(start), .route_len(route_len),
      .route_we(route_we), .route_waddr(route_waddr), .route_wdata(route_wdata),
      .nodes(nodes), .turn_done(turn_done), .sample_done(sample_done),
      .reset_count(reset_count), .follow_en(follow_en), .turn_req(turn_req),
      .turn_cmd(turn_cmd), .sample_req(sample_req), .node_index(node_index),
      .busy(busy), .done(done), .fault(fault)
   );

   typedef struct {
      logic [5:0] from_n;
      logic [5:0] to_n;
      logic       exp_turn;
      logic       exp_fault;
   } vec_t;

   typedef struct {
      int         kind;   // 0 turn, 1 sample, 2 end, 3 reserved
      logic [1:0] cmd;
      logic [3:0] idx;
   } ev_t;

   function automatic logic [12:0] outs();
      return {reset_count, follow_en, turn_req, turn_cmd, sample_req, node_index, busy, done, fault};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk_50);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; route_we = 1'b0; turn_done = 1'b0; sample_done = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic write_entry(input int a, input int d);
      route_we = 1'b1; route_waddr = 4'(a); route_wdata = 3'(d);
      tick();
      route_we = 1'b0;
   endtask

   task automatic pulse_start(input int len);
      start = 1'b1; route_len = 5'(len);
      tick();
      start = 1'b0;
   endtask

   task automatic step_nodes(input int v);
      nodes = 6'(v);
      tick(); tick();
   endtask

   // Randomized route against a model built only from the action-code rules.
   task automatic run_random();
      logic [2:0] tbl [16];
      int len, idx, n, d, r, final_idx;
      bit adv_done;
      ev_t q[$];
      ev_t e;
      len = $urandom_range(0, 16);
      for (int i = 0; i < 16; i++) begin
         r = $urandom_range(0, 99);
         if (r < 80) tbl[i] = 3'($urandom_range(0, 4));
         else if (r < 90) tbl[i] = 3'd5;
         else tbl[i] = 3'($urandom_range(6, 7));
      end
      do_reset();
      for (int i = 0; i < 16; i++) write_entry(i, int'(tbl[i]));

      adv_done = 1'b0; idx = 0; final_idx = 0;
      if (len > 0) begin
         for (int k = 0; k < 17; k++) begin
            e.kind = (tbl[idx] < 3'd4) ? 0 : (tbl[idx] == 3'd4) ? 1 : (tbl[idx] == 3'd5) ? 2 : 3;
            e.cmd  = tbl[idx][1:0];
            e.idx  = 4'(idx);
            q.push_back(e);
            if (e.kind >= 2) begin
               final_idx = idx;
               break;
            end
            idx++;
            if (idx == len) begin
               adv_done = 1'b1;
               final_idx = idx % 16;
               break;
            end
         end
      end

      n = 0; nodes = 6'd0;
      pulse_start(len);
      if (len == 0) begin
         check("rnd_len0_done", done, 1);
         check("rnd_len0_rc", reset_count, 0);
         return;
      end
      check("rnd_rc", reset_count, 1);
      tick();
      check("rnd_follow", follow_en, 1);
      for (int i = 0; i < q.size(); i++) begin
         e = q[i];
         if ($urandom_range(0, 3) == 0 && n != 63) begin
            n = 0; nodes = 6'd0; tick();
         end
         n = (n + 1) % 64;
         step_nodes(n);
         case (e.kind)
            0: begin
               check("rnd_turn_req", turn_req, 1);
               check("rnd_turn_cmd", turn_cmd, e.cmd);
               check("rnd_turn_idx", node_index, e.idx);
            end
            1: begin
               check("rnd_sample_req", sample_req, 1);
               check("rnd_sample_follow", follow_en, 0);
               check("rnd_sample_idx", node_index, e.idx);
            end
            2: begin
               check("rnd_end_done", done, 1);
               check("rnd_end_idx", node_index, final_idx);
            end
            default: begin
               check("rnd_rsvd_fault", fault, 1);
               check("rnd_rsvd_req", {turn_req, sample_req}, 0);
            end
         endcase
         if (e.kind < 2) begin
            d = $urandom_range(0, 8);
            for (int j = 0; j < d; j++) begin
               route_we = ($urandom_range(0, 2) == 0);
               route_waddr = 4'($urandom_range(0, 15));
               route_wdata = 3'($urandom_range(0, 7));
               if ($urandom_range(0, 3) == 0) begin
                  n = $urandom_range(0, 63);
                  nodes = 6'(n);
               end
               tick();
            end
            route_we = 1'b0;
            check("rnd_req_held", {turn_req, sample_req}, (e.kind == 0) ? 2 : 1);
            if (e.kind == 0) turn_done = 1'b1; else sample_done = 1'b1;
            tick();
            turn_done = 1'b0; sample_done = 1'b0;
            check("rnd_req_release", {turn_req, sample_req}, 0);
            tick();
            if (i == q.size() - 1 && adv_done) begin
               check("rnd_adv_done", done, 1);
               check("rnd_adv_idx", node_index, final_idx);
            end else begin
               check("rnd_refollow", follow_en, 1);
            end
         end
      end
   endtask

   vec_t vecs [8];
   int   cnt;
   bit   held, rc_seen;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
      $fatal(1);
   end

   initial begin
      vecs[0] = '{6'd2,  6'd3,  1'b1, 1'b0};
      vecs[1] = '{6'd2,  6'd5,  1'b0, 1'b1};
      vecs[2] = '{6'd2,  6'd0,  1'b0, 1'b0};
      vecs[3] = '{6'd63, 6'd0,  1'b1, 1'b0};
      vecs[4] = '{6'd7,  6'd7,  1'b0, 1'b0};
      vecs[5] = '{6'd10, 6'd9,  1'b0, 1'b1};
      vecs[6] = '{6'd0,  6'd1,  1'b1, 1'b0};
      vecs[7] = '{6'd62, 6'd63, 1'b1, 1'b0};

      // Basic route [left, right, end], length 3
      do_reset();
      check("reset_outs", outs(), 0);
      write_entry(0, 1); write_entry(1, 2); write_entry(2, 5);
      nodes = 6'd0;
      pulse_start(3);
      check("clear_rc", reset_count, 1);
      check("clear_follow", follow_en, 0);
      tick();
      check("rc_single", reset_count, 0);
      check("follow_on", follow_en, 1);
      step_nodes(1);
      check("t1_req", turn_req, 1);
      check("t1_cmd", turn_cmd, 2'b01);
      check("t1_idx", node_index, 0);
      turn_done = 1'b1; tick(); turn_done = 1'b0;
      check("t1_release", turn_req, 0);
      check("t1_adv_nofollow", follow_en, 0);
      tick();
      check("t1_refollow", follow_en, 1);
      nodes = 6'd0; tick();
      check("drop0_ignored", {follow_en, fault}, 2'b10);
      step_nodes(1);
      check("t2_req", turn_req, 1);
      check("t2_cmd", turn_cmd, 2'b10);
      check("t2_idx", node_index, 1);
      turn_done = 1'b1; tick(); turn_done = 1'b0; tick();
      step_nodes(2);
      check("end_done", done, 1);
      check("end_idx", node_index, 2);
      check("end_busy_follow", {busy, follow_en}, 0);

      // Sample entry, length 1
      do_reset();
      write_entry(0, 4);
      nodes = 6'd0;
      pulse_start(1); tick();
      step_nodes(1);
      check("s_req", sample_req, 1);
      check("s_follow_low", follow_en, 0);
      held = 1'b1;
      repeat (50) begin
         tick();
         if (!sample_req) held = 1'b0;
      end
      check("s_held", held, 1);
      sample_done = 1'b1; tick(); sample_done = 1'b0;
      check("s_release", {sample_req, done}, 0);
      tick();
      check("s_done", done, 1);

      // Turn timeout
      do_reset();
      write_entry(0, 3);
      nodes = 6'd0;
      pulse_start(1); tick();
      step_nodes(1);
      check("to_cmd", turn_cmd, 2'b11);
      cnt = 0;
      while (turn_req && cnt < 3 * TT) begin
         cnt++;
         tick();
      end
      check("to_cycles", cnt, TT);
      check("to_fault", fault, 1);
      check("to_req_low", {turn_req, busy}, 0);
      pulse_start(2);
      check("to_start_ignored", {fault, reset_count}, 2'b10);
      tick();
      check("to_still_fault", {fault, follow_en}, 2'b10);
      reset = 1'b1; tick(); reset = 1'b0;
      check("to_reset_clears", fault, 0);

      // route_len 0
      do_reset();
      pulse_start(0);
      check("len0_done", done, 1);
      rc_seen = reset_count;
      repeat (3) begin
         tick();
         rc_seen |= reset_count;
      end
      check("len0_no_rc", rc_seen, 0);
      check("len0_still_done", done, 1);

      // Write together with start in IDLE
      do_reset();
      nodes = 6'd0;
      route_we = 1'b1; route_waddr = 4'd0; route_wdata = 3'd3;
      pulse_start(1);
      route_we = 1'b0;
      check("wstart_rc", reset_count, 1);
      tick();
      step_nodes(1);
      check("wstart_cmd", turn_cmd, 2'b11);
      turn_done = 1'b1; tick(); turn_done = 1'b0; tick();
      check("wstart_done", {done, node_index}, 5'b1_0001);

      // Writes during TURN are ignored, then reset mid-TURN
      do_reset();
      write_entry(0, 1); write_entry(1, 5);
      nodes = 6'd0;
      pulse_start(2); tick();
      step_nodes(1);
      check("wturn_req", turn_req, 1);
      write_entry(0, 2);
      write_entry(1, 6);
      turn_done = 1'b1; tick(); turn_done = 1'b0; tick();
      step_nodes(2);
      check("wturn_entry1_kept", {done, fault}, 2'b10);
      nodes = 6'd0; tick();
      pulse_start(2); tick();
      step_nodes(1);
      check("wturn_entry0_kept", {turn_req, turn_cmd}, 3'b101);
      reset = 1'b1; tick(); reset = 1'b0;
      check("midturn_reset", outs(), 0);

      // Node-change vectors applied from FOLLOW
      do_reset();
      write_entry(0, 1); write_entry(1, 2);
      for (int v = 0; v < 8; v++) begin
         do_reset();
         nodes = 6'd0;
         pulse_start(16); tick();
         step_nodes(1);
         nodes = vecs[v].from_n; tick();
         turn_done = 1'b1; tick(); turn_done = 1'b0; tick();
         check($sformatf("vec%0d_follow", v), follow_en, 1);
         nodes = vecs[v].to_n;
         tick(); tick();
         check($sformatf("vec%0d_turn", v), turn_req, vecs[v].exp_turn);
         check($sformatf("vec%0d_fault", v), fault, vecs[v].exp_fault);
      end

      for (int it = 0; it < 25; it++) run_random();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/sm_route_sequencer.md
# sm_route_sequencer

Route controller for the soil-monitoring bot. It holds a programmable table of per-node actions and watches the node count from the node detector. At each new node it commands the motor/turn block or the soil-sampling block through request/done handshakes. It sits between the node detector (drives `reset_count` and reads `nodes`) and the motion/sampling controllers, and gates line following with `follow_en`.

## Interface
- `ROUTE_DEPTH`, 16: number of action-table entries, indexed 0..15 by a 4-bit address.
- `TURN_TIMEOUT`, 100_000_000: maximum cycles to wait for `turn_done` (2 s at 50 MHz).
- `SAMPLE_TIMEOUT`, 500_000_000: maximum cycles to wait for `sample_done`.

Ports:
- `clk_50`  in  1: the single clock. All logic is on its rising edge.
- `reset`  in  1: synchronous, active-high. Forces all state and outputs to their reset values.
- `start`  in  1: one-cycle pulse that begins the route. Accepted only in IDLE or DONE.
- `route_len`  in  5: number of valid entries, 0..16. Sampled on an accepted `start`.
- `route_we`  in  1: action-table write strobe. Ignored while `busy`.
- `route_waddr`  in  4: table write address.
- `route_wdata`  in  3: action code to write.
- `nodes`  in  6: node count from the node detector.
- `turn_done`  in  1: motor block has finished the commanded turn.
- `sample_done`  in  1: sampler has finished sampling.
- `reset_count`  out  1: clears the node detector's count.
- `follow_en`  out  1: enables line following.
- `turn_req`  out  1: turn request. Held high until `turn_done` is seen.
- `turn_cmd`  out  2: turn code: 00 straight, 01 left, 10 right, 11 U-turn. Stable while `turn_req` is high.
- `sample_req`  out  1: sampling request. Held high until `sample_done` is seen.
- `node_index`  out  4: index of the current or next table entry.
- `busy`  out  1: high in every state except IDLE, DONE and FAULT.
- `done`  out  1: high in DONE.
- `fault`  out  1: high in FAULT.

## Operation
- Action codes:
  - 000 straight, 001 left, 010 right, 011 U-turn.
  - 100 sample, then continue straight.
  - 101 end.
  - 110 and 111 are reserved and cause FAULT.
- Table: 16×3 register array. Contents are not cleared by `reset`.
- Node event:
  - `prev_nodes` is a register updated every cycle.
  - An event occurs when `nodes == prev_nodes + 1` (mod 64, so 63→0 counts as an event).
  - A change to 0 that is not from 63 is ignored; the detector zeroes its count on its own.
  - Any other change (a jump of more than 1) causes FAULT, but only in FOLLOW.
- State machine:
  - IDLE: all outputs 0. An accepted `start` latches `route_len`, sets `node_index` = 0 and goes to CLEAR. If `route_len` == 0, it goes directly to DONE.
  - CLEAR: `reset_count` = 1 for exactly one cycle. `prev_nodes` is loaded with 0. Next state is FOLLOW.
  - FOLLOW: `follow_en` = 1. A node event goes to FETCH.
  - FETCH (1 cycle): reads `table[node_index]`.
    - Codes 000–011: `turn_cmd` gets the code, go to TURN.
    - Code 100: go to SAMPLE.
    - Code 101: go to DONE.
    - Reserved code: go to FAULT.
  - TURN: `turn_req` = 1. On `turn_done`, go to ADVANCE. If the timer reaches `TURN_TIMEOUT`, go to FAULT.
  - SAMPLE: `follow_en` = 0 and `sample_req` = 1. On `sample_done`, go to ADVANCE. If the timer reaches `SAMPLE_TIMEOUT`, go to FAULT.
  - ADVANCE (1 cycle): `node_index` increments. If the new index equals the latched `route_len`, go to DONE; otherwise go to FOLLOW.
  - DONE: `done` = 1 and `follow_en` = 0. An accepted `start` restarts the route exactly as from IDLE.
  - FAULT: `fault` = 1 and all requests 0. Only `reset` leaves this state.
- Timeout timer: 32 bits. Cleared on entry to TURN or SAMPLE; increments every cycle while in them.
- Simultaneous events:
  - `route_we` together with `start` in IDLE: the write is performed and `start` is accepted.
  - Node events outside FOLLOW: ignored. `prev_nodes` still tracks `nodes`.
  - `turn_done` outside TURN and `sample_done` outside SAMPLE: ignored.

## Timing
- Reset values: all outputs 0; state IDLE; `node_index` 0; timer 0; `prev_nodes` 0.
- Start to clear: `start` accepted in cycle n, `reset_count` high in cycle n+1, `follow_en` high from cycle n+2.
- Node to request: `nodes` increments in cycle n, event seen in cycle n+1 (FOLLOW→FETCH), `turn_req` or `sample_req` high in cycle n+2.
- Request release: `done` input high in cycle m, request low in cycle m+1, `follow_en` high again in cycle m+2.
- A mid-operation `reset` drops every request and status output in the following cycle.

## Test plan
- Load table [001, 010, 101] with `route_len` = 3, pulse `start`:
  - `reset_count` is a single-cycle pulse.
  - Step `nodes` 0→1: `turn_cmd` = 01; return `turn_done`.
  - Step `nodes` 1→0→1: `turn_cmd` = 10.
  - Next event: `done` = 1 and `node_index` = 2.
- Entry 0 = 100, `route_len` = 1:
  - Node event: `sample_req` goes high and `follow_en` goes low.
  - `sample_done` after 50 cycles: `done` next cycle +1.
- Withhold `turn_done` for `TURN_TIMEOUT` cycles: `fault` = 1 and `turn_req` = 0. A later `start` is ignored; `reset` clears `fault`.
- In FOLLOW, jump `nodes` 2→5: FAULT. Separately, a 63→0 step is a valid event.
- `route_len` = 0 with `start`: `done` next cycle, and `reset_count` never asserts.
- Assert `route_we` while in TURN: table contents are unchanged. Assert `reset` mid-TURN: `turn_req` = 0 next cycle and state is IDLE.
